dly_tap_ctrl: RTL and testbench

//  Per-line delay tap controller, directly downstream of the delay select decoder.

---
 rtl/dly_tap_ctrl.sv | 115 +++++++++++
 tb/tb_dly_tap_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dly_tap_ctrl.sv
// Per-line delay tap controller: edge-triggered load/adjust of one tap value with a busy settle window.
// Optional macro DLY_TAP_WRAP_EN makes adjust wrap at 0/MAX_TAP instead of saturating.
module dly_tap_ctrl #(
  parameter int TAP_W         = 6,
  parameter int MAX_TAP       = 63,
  parameter int RESET_TAP     = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       DLY_CNTRL,
  input  logic [TAP_W-1:0] DLY_TAP_INIT,
  output logic [TAP_W-1:0] DLY_TAP_VALUE,
  output logic             DLY_BUSY,
  output logic             DLY_SAT,
  output logic             DLY_DROP
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TAP_W-1:0] MAX_V    = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] RST_V    = TAP_W'(RESET_TAP);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [TAP_W-1:0] tap, tap_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             drop, drop_nxt;
  logic             load_q, adj_q;

  logic             load, adj, incdec;
  logic             ld_e, adj_e;
  logic             at_lim, step_ok;
  logic [TAP_W-1:0] init_clamp, adj_tap;

  assign load   = DLY_CNTRL[2];
  assign adj    = DLY_CNTRL[1];
  assign incdec = DLY_CNTRL[0];
  assign ld_e   = load & ~load_q;
  assign adj_e  = adj & ~adj_q;

  assign init_clamp = (DLY_TAP_INIT > MAX_V) ? MAX_V : DLY_TAP_INIT;
  assign at_lim     = incdec ? (tap == MAX_V) : (tap == '0);

`ifdef DLY_TAP_WRAP_EN
  assign step_ok = 1'b1;
  assign adj_tap = at_lim ? (incdec ? '0 : MAX_V)
                          : (incdec ? tap + 1'b1 : tap - 1'b1);
`else
  // Step is only taken away from the limit, so +/-1 never overflows TAP_W bits
  assign step_ok = ~at_lim;
  assign adj_tap = incdec ? tap + 1'b1 : tap - 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      tap    <= RST_V;
      cnt    <= '0;
      drop   <= 1'b0;
      load_q <= 1'b0;
      adj_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tap    <= tap_nxt;
      cnt    <= cnt_nxt;
      drop   <= drop_nxt;
      load_q <= load;
      adj_q  <= adj;
    end
  end

  always_comb begin
    state_nxt = state;
    tap_nxt   = tap;
    cnt_nxt   = cnt;
    drop_nxt  = 1'b0;
    if (ld_e) begin
      // Load wins in any state; a coincident adjust edge is reported as dropped
      tap_nxt   = init_clamp;
      state_nxt = SETTLE;
      cnt_nxt   = CNT_INIT;
      drop_nxt  = adj_e;
    end else begin
      case (state)
        IDLE: begin
          if (adj_e && step_ok) begin
            tap_nxt   = adj_tap;
            state_nxt = SETTLE;
            cnt_nxt   = CNT_INIT;
          end
        end
        SETTLE: begin
          drop_nxt = adj_e;
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    DLY_TAP_VALUE = tap;
    DLY_BUSY      = (state == SETTLE);
    DLY_DROP      = drop;
`ifdef DLY_TAP_WRAP_EN
    DLY_SAT       = 1'b0;
`else
    DLY_SAT       = (tap == '0) || (tap == MAX_V);
`endif
  end

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Directed bench for dly_tap_ctrl; a second TAP_W=7 instance covers init clamping.
module tb_dly_tap_ctrl;

`ifdef DLY_TAP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cntrl, cntrl2;
  logic [5:0] init;
  logic [6:0] init2;
  logic [5:0] tap;
  logic [6:0] tap2;
  logic       busy, sat, drop, busy2, sat2, drop2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dly_tap_ctrl dut (
    .CLK(clk), .RST(rst), .DLY_CNTRL(cntrl), .DLY_TAP_INIT(init),
    .DLY_TAP_VALUE(tap), .DLY_BUSY(busy), .DLY_SAT(sat), .DLY_DROP(drop)
  );

  dly_tap_ctrl #(.TAP_W(7), .MAX_TAP(63)) dut7 (
    .CLK(clk), .RST(rst), .DLY_CNTRL(cntrl2), .DLY_TAP_INIT(init2),
    .DLY_TAP_VALUE(tap2), .DLY_BUSY(busy2), .DLY_SAT(sat2), .DLY_DROP(drop2)
  );

  // Expected {tap, busy, sat, drop}; sat derived from the expected tap
  function automatic logic [8:0] exp_obs(input int t, input bit b, input bit d);
    logic [5:0] tv;
    logic       s;
    tv = 6'(t);
    s  = WRAP ? 1'b0 : ((tv == 6'd0) || (tv == 6'd63));
    return {tv, b, s, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    rst = 1'b1; cntrl = 3'b000; cntrl2 = 3'b000; init = '0; init2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    e = exp_obs(0, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL reset_state got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    total_cnt++;
    if ({tap2, busy2, drop2} !== 9'd0)
      $display("FAIL reset_state7 got tap=%0d busy=%b drop=%b want 0/0/0", tap2, busy2, drop2);
    else pass_cnt++;
  endtask

  task automatic test_load();
    logic [8:0] e;
    init = 6'd37; cntrl = 3'b100;
    // LOAD held high throughout: one edge only, busy exactly 4 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_obs(37, (i < 4), 0);
      total_cnt++;
      if ({tap, busy, sat, drop} !== e)
        $display("FAIL load_cycle%0d got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", i, tap, {busy, sat, drop}, e[8:3], e[2:0]);
      else pass_cnt++;
    end
    cntrl = 3'b000;
    tick();
  endtask

  task automatic test_adj();
    logic [8:0] e [6];
    logic [2:0] v [6];
    v = '{3'b011, 3'b000, 3'b011, 3'b000, 3'b000, 3'b010};
    e = '{exp_obs(38, 1, 0), exp_obs(38, 1, 0), exp_obs(38, 1, 1),
          exp_obs(38, 1, 0), exp_obs(38, 0, 0), exp_obs(37, 1, 0)};
    for (int i = 0; i < 6; i++) begin
      cntrl = v[i];
      tick();
      total_cnt++;
      if ({tap, busy, sat, drop} !== e[i])
        $display("FAIL adj_step%0d got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", i, tap, {busy, sat, drop}, e[i][8:3], e[i][2:0]);
      else pass_cnt++;
    end
    cntrl = 3'b000;
    repeat (4) tick();
    total_cnt++;
    if ({tap, busy, drop} !== {6'd37, 1'b0, 1'b0})
      $display("FAIL back_to_back_idle got tap=%0d busy=%b drop=%b want 37/0/0", tap, busy, drop);
    else pass_cnt++;
  endtask

  task automatic test_limit();
    logic [8:0] e;
    init = 6'd63; cntrl = 3'b100; tick();
    cntrl = 3'b000; repeat (4) tick();
    e = exp_obs(63, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL limit_max_load got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b011; tick();
    e = WRAP ? exp_obs(0, 1, 0) : exp_obs(63, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL limit_inc got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b000; repeat (4) tick();
    init = 6'd0; cntrl = 3'b100; tick();
    cntrl = 3'b000; repeat (4) tick();
    e = exp_obs(0, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL limit_zero_load got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b010; tick();
    e = WRAP ? exp_obs(63, 1, 0) : exp_obs(0, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL limit_dec got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b000; repeat (4) tick();
  endtask

  task automatic test_simul();
    logic [8:0] e;
    init = 6'd5; cntrl = 3'b110;
    init2 = 7'd70; cntrl2 = 3'b100;
    tick();
    e = exp_obs(5, 1, 1);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL simul_load_adj got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    total_cnt++;
    if (tap2 !== 7'd63)
      $display("FAIL init_clamp got %0d want 63", tap2);
    else pass_cnt++;
    cntrl = 3'b000; cntrl2 = 3'b000;
    tick();
    e = exp_obs(5, 1, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL simul_drop_clear got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({busy, busy2} !== 2'b00)
      $display("FAIL simul_settle_end got busy=%b busy7=%b want 0/0", busy, busy2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    init = 6'd20; cntrl = 3'b100; tick();
    cntrl = 3'b000; tick();
    e = exp_obs(20, 1, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL rstmid_busy2 got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    rst = 1'b1; tick();
    e = exp_obs(0, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL rstmid_abort got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b011; tick();
    rst = 1'b0; tick();
    e = exp_obs(1, 1, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL rst_release_edge got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    repeat (5) tick();
    e = exp_obs(1, 0, 0);
    total_cnt++;
    if ({tap, busy, sat, drop} !== e)
      $display("FAIL level_hold got tap=%0d b/s/d=%b want tap=%0d b/s/d=%b", tap, {busy, sat, drop}, e[8:3], e[2:0]);
    else pass_cnt++;
    cntrl = 3'b000; tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_adj();
    test_limit();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
